// File: rtl/alu_cmd_sequencer_pkg.sv
// Shared types and constants for the ALU command sequencer: instruction layout,
// sequencer states and the opcode values understood by the ALU decoder.
package alu_seq_pkg;

  localparam int INSTR_W  = 48;

  localparam int OPC_MSB  = 47;
  localparam int OPC_LSB  = 44;
  localparam int SEL_BIT  = 43;
  localparam int BSEL_MSB = 42;
  localparam int BSEL_LSB = 41;
  localparam int ADR_MSB  = 40;
  localparam int ADR_LSB  = 35;
  localparam int END_BIT  = 34;
  localparam int RSV_MSB  = 33;
  localparam int RSV_LSB  = 32;
  localparam int A_MSB    = 31;
  localparam int A_LSB    = 0;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    ISSUE = 3'd2,
    HOLD  = 3'd3,
    DONE  = 3'd4
  } seq_state_t;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_MULT = 4'b0010;
  localparam logic [3:0] OP_ADDI = 4'b0111;

endpackage

// File: rtl/alu_cmd_sequencer_imem.sv
// Program store: DEPTH x INSTR_W RAM, one write port, registered read port.
// The read register clears on reset so the command fields start at zero.
module alu_seq_imem
  import alu_seq_pkg::*;
#(
  parameter int DEPTH = 64,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_addr,
  input  logic [INSTR_W-1:0] wr_data,
  input  logic               rd_en,
  input  logic [AW-1:0]      rd_addr,
  output logic [INSTR_W-1:0] rd_data
);

  logic [INSTR_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Only updates on a fetch, so the issued fields stay stable through ISSUE and HOLD.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Issues a stored ALU program one command at a time over valid/ready with a hold window.
// Build option SEQ_LOOP_EN adds loop_count to repeat the program loop_count+1 times.
module alu_cmd_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DEPTH       = 64,
  parameter int HOLD_CYCLES = 2,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
`ifdef SEQ_LOOP_EN
  input  logic [7:0]         loop_count,
`endif
  input  logic               pw_en,
  input  logic [AW-1:0]      pw_addr,
  input  logic [INSTR_W-1:0] pw_data,
  output logic               pw_err,
  output logic               busy,
  output logic               done,
  output logic [AW-1:0]      pc,
  output logic               cmd_valid,
  input  logic               cmd_ready,
  output logic [3:0]         opcode,
  output logic               sel,
  output logic [1:0]         bsel,
  output logic [5:0]         adr,
  output logic [31:0]        A
);

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  seq_state_t         state_q;
  seq_state_t         state_d;
  logic [HW-1:0]      hold_cnt;
  logic [INSTR_W-1:0] instr;
  logic               rd_en;
  logic               wr_ok;
  logic               hold_last;
  logic               prog_end;
  logic               more_loops;
  logic               unused_rsv;

  alu_seq_imem #(.DEPTH(DEPTH)) u_imem (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (pw_en && wr_ok),
    .wr_addr (pw_addr),
    .wr_data (pw_data),
    .rd_en   (rd_en),
    .rd_addr (pc),
    .rd_data (instr)
  );

  assign opcode     = instr[OPC_MSB:OPC_LSB];
  assign sel        = instr[SEL_BIT];
  assign bsel       = instr[BSEL_MSB:BSEL_LSB];
  assign adr        = instr[ADR_MSB:ADR_LSB];
  assign A          = instr[A_MSB:A_LSB];
  assign unused_rsv = ^instr[RSV_MSB:RSV_LSB];

  assign hold_last  = (hold_cnt == HW'(HOLD_CYCLES - 1));
  // The last physical entry ends the pass even without END: no wrap-around.
  assign prog_end   = instr[END_BIT] || (pc == AW'(DEPTH - 1));

`ifdef SEQ_LOOP_EN
  logic [7:0] loop_rem;
  assign more_loops = (loop_rem != 8'd0);
`else
  assign more_loops = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start) state_d = FETCH;
        FETCH:   state_d = ISSUE;
        ISSUE:   if (cmd_ready) state_d = HOLD;
        HOLD:    if (hold_last) state_d = (prog_end && !more_loops) ? DONE : FETCH;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    busy      = (state_q != IDLE);
    done      = (state_q == DONE);
    cmd_valid = (state_q == ISSUE);
    rd_en     = (state_q == FETCH);
    wr_ok     = (state_q == IDLE) || (state_q == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc       <= '0;
      hold_cnt <= '0;
      pw_err   <= 1'b0;
`ifdef SEQ_LOOP_EN
      loop_rem <= 8'd0;
`endif
    end else begin
      pw_err <= pw_en && !wr_ok;
      if (!abort) begin
        case (state_q)
          IDLE: begin
            if (start) begin
              pc <= '0;
`ifdef SEQ_LOOP_EN
              loop_rem <= loop_count;
`endif
            end
          end
          ISSUE: hold_cnt <= '0;
          HOLD: begin
            if (!hold_last) begin
              hold_cnt <= hold_cnt + HW'(1);
            end else if (!prog_end) begin
              pc <= pc + AW'(1);
            end else if (more_loops) begin
              pc <= '0;
`ifdef SEQ_LOOP_EN
              loop_rem <= loop_rem - 8'd1;
`endif
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
